// File: rtl/uart_mem_loader.sv
// Frame parser between the UART byte receiver and the word-wide memory write port.
// Frame: SYNC, start address, word count, {lo, hi} per word, XOR checksum of the data bytes.

module uart_mem_loader_chk #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            busy,
  input  logic            done,
  input  logic            err,
  input  logic [1:0]      err_code,
  input  logic [ADDR_W:0] word_cnt
);

  a_wr_in_frame: assert property (@(posedge clk) disable iff (reset) wr_en |-> busy);
  a_done_clean:  assert property (@(posedge clk) disable iff (reset) done |-> (!busy && !err));
  a_done_pulse:  assert property (@(posedge clk) disable iff (reset) done |=> !done);
  a_code_err:    assert property (@(posedge clk) disable iff (reset) err == (err_code != 2'b00));

endmodule

module uart_mem_loader #(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 10,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] HI_MASK_W = 16'hFFFF << (DATA_W - 8);
  localparam logic [7:0]  HI_MASK   = HI_MASK_W[7:0];

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_FMT  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_LEN     = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CHK     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [7:0]          lo_q, lo_d;
  logic [7:0]          chk_q, chk_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;

  logic [TMO_W-1:0]    tmo_inc_s;
  logic [ADDR_W-1:0]   len_s;

  // Next-state, datapath and status computation for one received byte or idle cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    lo_d       = lo_q;
    chk_d      = chk_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    word_cnt_d = word_cnt_q;
    tmo_inc_s  = tmo_q + TMO_W'(1);
    len_s      = ADDR_W'(rx_data);

    if ((state_q == S_IDLE) || rx_valid) begin
      tmo_d = {TMO_W{1'b0}};
    end else begin
      tmo_d = tmo_inc_s;
    end

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d    = S_ADDR;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            word_cnt_d = {(ADDR_W+1){1'b0}};
            chk_d      = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          ptr_d   = ADDR_W'(rx_data);
          state_d = S_LEN;
        end
        S_LEN: begin
          // A zero length byte means a full memory's worth of words.
          if (len_s == {ADDR_W{1'b0}}) begin
            remain_d = {1'b1, {ADDR_W{1'b0}}};
          end else begin
            remain_d = {1'b0, len_s};
          end
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          lo_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          chk_d = chk_q ^ rx_data;
          if ((rx_data & HI_MASK) != 8'h00) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_FMT;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = {rx_data[DATA_W-9:0], lo_q};
            ptr_d      = ptr_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
            remain_d   = remain_q - (ADDR_W+1)'(1);
            if (remain_q == (ADDR_W+1)'(1)) begin
              state_d = S_CHK;
            end else begin
              state_d = S_DATA_LO;
            end
          end
        end
        S_CHK: begin
          if (rx_data == chk_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if ((state_q != S_IDLE) && (tmo_inc_s == TMO_W'(TIMEOUT_CYC))) begin
      state_d    = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      tmo_d      = {TMO_W{1'b0}};
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any partially assembled word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= {ADDR_W{1'b0}};
      remain_q   <= {(ADDR_W+1){1'b0}};
      lo_q       <= 8'h00;
      chk_q      <= 8'h00;
      tmo_q      <= {TMO_W{1'b0}};
      wr_en_q    <= 1'b0;
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {DATA_W{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      word_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      lo_q       <= lo_d;
      chk_q      <= chk_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign word_cnt = word_cnt_q;

  uart_mem_loader_chk #(
    .ADDR_W(ADDR_W)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .word_cnt (word_cnt)
  );

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: a frame-position model predicts every output each cycle,
// and directed frames pin the model with hand-computed writes and status values.

module tb_uart_mem_loader;

  localparam int TMO = 50000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [9:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [8:0] word_cnt;

  int checks = 0;
  int failures = 0;

  // model of the frame stream: position of the next byte inside the frame
  bit         in_frame;
  int         idx, nwords, base, gap;
  logic [7:0] lo_m, xacc;
  logic       e_wr_en, e_busy, e_done, e_err;
  logic [7:0] e_addr;
  logic [9:0] e_data;
  logic [1:0] e_code;
  logic [8:0] e_cnt;

  logic [17:0] wlog[$];
  int          done_cnt;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .ADDR_W(8), .DATA_W(10), .SYNC_BYTE(8'h55), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .word_cnt(word_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {31'd0, wr_en, wr_addr, wr_data, busy, done, err, err_code, word_cnt};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {31'd0, e_wr_en, e_addr, e_data, e_busy, e_done, e_err, e_code, e_cnt};
  endfunction

  function automatic logic [17:0] getw(input int i);
    return (wlog.size() > i) ? wlog[i] : 18'h3FFFF;
  endfunction

  task automatic model_reset();
    in_frame = 1'b0; idx = 0; nwords = 0; base = 0; gap = 0;
    lo_m = 8'h00; xacc = 8'h00;
    e_wr_en = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_addr = 8'h00; e_data = 10'h000; e_code = 2'b00; e_cnt = 9'd0;
  endtask

  // Outputs expected right after the next clock edge, given this cycle's byte input.
  task automatic model_step(input logic v, input logic [7:0] d);
    e_wr_en = 1'b0;
    e_done  = 1'b0;
    if (!in_frame) begin
      if (v && d == 8'h55) begin
        in_frame = 1'b1; idx = 0; gap = 0; xacc = 8'h00;
        e_err = 1'b0; e_code = 2'b00; e_cnt = 9'd0;
      end
    end else if (v) begin
      gap = 0;
      if (idx == 0) begin
        base = int'(d);
      end else if (idx == 1) begin
        nwords = (d == 8'h00) ? 256 : int'(d);
      end else if (idx < 2 + 2 * nwords) begin
        xacc = xacc ^ d;
        if (idx % 2 == 0) begin
          lo_m = d;
        end else if (d > 8'd3) begin
          in_frame = 1'b0; e_err = 1'b1; e_code = 2'd2;
        end else begin
          e_wr_en = 1'b1;
          e_addr  = 8'((base + (idx - 2) / 2) % 256);
          e_data  = 10'(int'(d) * 256 + int'(lo_m));
          e_cnt   = e_cnt + 9'd1;
        end
      end else begin
        if (d == xacc) begin
          e_done = 1'b1;
        end else begin
          e_err = 1'b1; e_code = 2'd1;
        end
        in_frame = 1'b0;
      end
      idx++;
    end else begin
      gap++;
      if (gap == TMO) begin
        in_frame = 1'b0; e_err = 1'b1; e_code = 2'd3;
      end
    end
    e_busy = in_frame;
  endtask

  // compare process: checks every cycle on the falling edge, then advances the model
  initial begin
    model_reset();
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (wr_en) wlog.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
      if (reset) begin
        check("reset_outputs", dut_vec(), 64'd0);
        model_reset();
      end else begin
        check("cycle_outputs", dut_vec(), exp_vec());
        model_step(rx_valid, rx_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap_cyc);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap_cyc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(max_gap, 0)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    done_cnt = 0;
  endtask

  task automatic check_f1(input string tag);
    check({tag, "_nwr"},  64'(wlog.size()), 64'(2));
    check({tag, "_w0"},   64'(getw(0)), 64'({8'h10, 10'h134}));
    check({tag, "_w1"},   64'(getw(1)), 64'({8'h11, 10'h3FF}));
    check({tag, "_done"}, 64'(done_cnt), 64'(1));
    check({tag, "_err"},  64'(err), 64'(0));
    check({tag, "_cnt"},  64'(word_cnt), 64'(2));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic [7:0] f1[$];
  logic [7:0] q[$];
  logic [7:0] x, lo, hi, stray;
  int         nw;
  bit         bad;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    // XOR of 34 01 FF 03 is C9
    f1 = '{8'h55, 8'h10, 8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'hC9};
    repeat (3) @(posedge clk);
    #1;
    check("rst_vec", dut_vec(), 64'd0);
    reset = 1'b0;
    idle(2);
    check("idle_busy", 64'(busy), 64'(0));

    // basic frame with random inter-byte gaps
    clear_log();
    send_frame(f1, 3);
    idle(3);
    check_f1("t1");

    // address wrap from FF to 00
    clear_log();
    send_frame('{8'h55, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03}, 2);
    idle(3);
    check("wrap_w0", 64'(getw(0)), 64'({8'hFF, 10'h001}));
    check("wrap_w1", 64'(getw(1)), 64'({8'h00, 10'h002}));
    check("wrap_done", 64'(done_cnt), 64'(1));

    // bad checksum: writes stay, checksum error flagged
    clear_log();
    send_frame('{8'h55, 8'h10, 8'h02, 8'h34, 8'h01, 8'hFF, 8'h03, 8'h00}, 1);
    idle(3);
    check("cerr_nwr", 64'(wlog.size()), 64'(2));
    check("cerr_done", 64'(done_cnt), 64'(0));
    check("cerr_code", 64'({err, err_code}), 64'({1'b1, 2'b01}));

    // format error, then stray bytes while idle
    clear_log();
    send_frame('{8'h55, 8'h10, 8'h02, 8'h34, 8'h04}, 1);
    idle(2);
    check("fmt_code", 64'({err, err_code}), 64'({1'b1, 2'b10}));
    check("fmt_busy", 64'(busy), 64'(0));
    send_frame('{8'h12, 8'h34, 8'h01, 8'h03}, 1);
    idle(2);
    check("fmt_nwr", 64'(wlog.size()), 64'(0));
    check("fmt_sticky", 64'(err_code), 64'(2));

    // stall after the lo byte until the timeout fires, then recover
    clear_log();
    send_frame('{8'h55, 8'h10, 8'h02, 8'h34}, 0);
    idle(TMO + 5);
    check("tmo_code", 64'({err, err_code}), 64'({1'b1, 2'b11}));
    check("tmo_busy", 64'(busy), 64'(0));
    check("tmo_nwr", 64'(wlog.size()), 64'(0));
    clear_log();
    send_frame(f1, 2);
    idle(3);
    check_f1("tmo_rec");

    // reset during the second hi byte, coinciding with its rx_valid
    clear_log();
    send_frame('{8'h55, 8'h10, 8'h02, 8'h34, 8'h01, 8'hFF}, 0);
    rx_data = 8'h03; rx_valid = 1'b1; reset = 1'b1;
    #1;
    check("rst_mid_vec", dut_vec(), 64'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(2);
    check("rst_mid_nwr", 64'(wlog.size()), 64'(1));
    clear_log();
    send_frame(f1, 2);
    idle(3);
    check_f1("rst_rec");

    // back-to-back bytes
    clear_log();
    send_frame(f1, 0);
    idle(3);
    check_f1("b2b");

    // random frames, including one full-depth frame
    for (int f = 0; f < 8; f++) begin
      nw = (f == 3) ? 0 : int'($urandom_range(6, 1));
      q = '{8'h55, 8'($urandom), 8'(nw)};
      x = 8'h00;
      bad = 1'b0;
      for (int w = 0; w < ((nw == 0) ? 256 : nw) && !bad; w++) begin
        lo = 8'($urandom);
        if (f != 3 && $urandom_range(15, 0) == 0) hi = 8'($urandom_range(255, 4));
        else hi = 8'($urandom_range(3, 0));
        q.push_back(lo);
        q.push_back(hi);
        x = x ^ lo ^ hi;
        if (hi > 8'd3) bad = 1'b1;
      end
      if (!bad) q.push_back(($urandom_range(3, 0) == 0) ? ~x : x);
      send_frame(q, 2);
      idle(3);
      stray = 8'($urandom);
      if (stray == 8'h55) stray = 8'h56;
      send_byte(stray, 1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
